// File: rtl/ws2812_pkg.sv
// ws2812_pkg: timing constants, pixel geometry and FSM state type shared by
// the WS2812 receiver and any transmitter model driving it.
// Ports: none (package).
package ws2812_pkg;

    localparam int T_THRESH  = 8;    // high time >= this decodes as '1'
    localparam int T_MIN     = 2;    // shortest legal high time
    localparam int T_MAX     = 14;   // longest legal high time
    localparam int T_LATCH   = 512;  // low time marking a latch gap
    localparam int PIX_W     = 24;
    localparam int IDX_W     = 10;
    localparam int BIT_CNT_W = $clog2(PIX_W + 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: decoded-pixel output bundle of the WS2812 receiver.
// Signals: pix_data (24b word, MSB first on the wire), pix_valid (1-cycle
// strobe), pix_idx (pixel index in frame), frame_end (latch-gap strobe),
// err (protocol-violation strobe).
// Modports: master = receiver side (drives), slave = consumer side.
interface ws2812_rx_if;
    import ws2812_pkg::*;

    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic [IDX_W-1:0] pix_idx;
    logic             frame_end;
    logic             err;

    modport master (output pix_data, output pix_valid, output pix_idx,
                    output frame_end, output err);
    modport slave  (input  pix_data, input  pix_valid, input  pix_idx,
                    input  frame_end, input  err);
endinterface

// File: rtl/ws2812_sync.sv
// ws2812_sync: two-flop synchronizer bringing the asynchronous WS2812 data
// line into the clk domain.
// Ports: clk, rst (sync, active high), din (async in), din_s (synchronized).
module ws2812_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic din_s
);
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], din};
    end

    assign din_s = sync_q[1];
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 serial decoder. Classifies each high pulse by length,
// assembles 24-bit pixel words and flags latch gaps and protocol errors.
// Ports: clk, rst (sync, active high), din (async serial in),
//        rx (ws2812_rx_if.master: pix_data/pix_valid/pix_idx/frame_end/err).
//
// state | meaning
// SYNC  | waiting for a full latch gap before trusting the line
// IDLE  | frame boundary seen, waiting for first rising edge
// HIGH  | measuring a high pulse
// LOW   | between bits, measuring low time for latch detection
module ws2812_rx #(
    parameter int T_THRESH = ws2812_pkg::T_THRESH,
    parameter int T_MIN    = ws2812_pkg::T_MIN,
    parameter int T_MAX    = ws2812_pkg::T_MAX,
    parameter int T_LATCH  = ws2812_pkg::T_LATCH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    ws2812_rx_if.master rx
);
    import ws2812_pkg::rx_state_e;
    import ws2812_pkg::SYNC;
    import ws2812_pkg::IDLE;
    import ws2812_pkg::HIGH;
    import ws2812_pkg::LOW;
    import ws2812_pkg::PIX_W;
    import ws2812_pkg::IDX_W;
    import ws2812_pkg::BIT_CNT_W;

    localparam int CNT_TOP = (T_LATCH > T_MAX + 1) ? T_LATCH : T_MAX + 1;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_SAT   = '1;
    localparam logic [CNT_W-1:0]     HI_THRESH = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0]     HI_MIN    = CNT_W'(T_MIN);
    localparam logic [CNT_W-1:0]     HI_MAX    = CNT_W'(T_MAX);
    localparam logic [CNT_W-1:0]     LO_LAST   = CNT_W'(T_LATCH - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(PIX_W - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);

    logic din_s, din_s_q, rise, fall;

    rx_state_e            state_q,     state_d;
    logic [CNT_W-1:0]     hi_cnt_q,    hi_cnt_d;
    logic [CNT_W-1:0]     lo_cnt_q,    lo_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [PIX_W-1:0]     sh_q,        sh_d;
    logic                 word_rdy_q,  word_rdy_d;
    logic [PIX_W-1:0]     pix_data_q,  pix_data_d;
    logic                 pix_valid_q, pix_valid_d;
    logic [IDX_W-1:0]     pix_idx_q,   pix_idx_d;
    logic                 frame_end_q, frame_end_d;
    logic                 err_q,       err_d;
    logic [CNT_W-1:0]     hi_inc, lo_inc;

    ws2812_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .din_s (din_s)
    );

    assign rise   = din_s & ~din_s_q;
    assign fall   = ~din_s & din_s_q;
    assign hi_inc = (hi_cnt_q == CNT_SAT) ? hi_cnt_q : hi_cnt_q + CNT_ONE;
    assign lo_inc = (lo_cnt_q == CNT_SAT) ? lo_cnt_q : lo_cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        hi_cnt_d    = hi_cnt_q;
        lo_cnt_d    = lo_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        word_rdy_d  = 1'b0;
        frame_end_d = 1'b0;
        err_d       = 1'b0;
        // A completed word is presented one cycle after the final shift.
        pix_valid_d = word_rdy_q;
        pix_data_d  = word_rdy_q ? sh_q : pix_data_q;
        pix_idx_d   = pix_valid_q ? pix_idx_q + IDX_ONE : pix_idx_q;

        case (state_q)
            SYNC: begin
                hi_cnt_d  = '0;
                bit_cnt_d = '0;
                sh_d      = '0;
                if (din_s) begin
                    lo_cnt_d = '0;
                end else if (lo_cnt_q >= LO_LAST) begin
                    lo_cnt_d  = '0;
                    pix_idx_d = '0;
                    state_d   = IDLE;
                end else begin
                    lo_cnt_d = lo_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d   = HIGH;
                    hi_cnt_d  = CNT_ONE;
                    bit_cnt_d = '0;
                    lo_cnt_d  = '0;
                end
            end
            HIGH: begin
                // An over-long pulse wins even if it ends this same cycle.
                if ((hi_cnt_q > HI_MAX) || (fall && (hi_cnt_q < HI_MIN))) begin
                    err_d     = 1'b1;
                    state_d   = SYNC;
                    hi_cnt_d  = '0;
                    lo_cnt_d  = '0;
                    bit_cnt_d = '0;
                    sh_d      = '0;
                end else if (fall) begin
                    sh_d     = {sh_q[PIX_W-2:0], (hi_cnt_q >= HI_THRESH)};
                    hi_cnt_d = '0;
                    lo_cnt_d = CNT_ONE;
                    state_d  = LOW;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d  = '0;
                        word_rdy_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    hi_cnt_d = hi_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d  = HIGH;
                    hi_cnt_d = CNT_ONE;
                end else if (lo_cnt_q >= LO_LAST) begin
                    frame_end_d = 1'b1;
                    err_d       = (bit_cnt_q != '0);
                    state_d     = IDLE;
                    lo_cnt_d    = '0;
                    bit_cnt_d   = '0;
                    sh_d        = '0;
                    pix_idx_d   = '0;
                end else begin
                    lo_cnt_d = lo_inc;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC;
            din_s_q     <= 1'b0;
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            word_rdy_q  <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_idx_q   <= '0;
            frame_end_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_s_q     <= din_s;
            hi_cnt_q    <= hi_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            word_rdy_q  <= word_rdy_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            pix_idx_q   <= pix_idx_d;
            frame_end_q <= frame_end_d;
            err_q       <= err_d;
        end
    end

    assign rx.pix_data  = pix_data_q;
    assign rx.pix_valid = pix_valid_q;
    assign rx.pix_idx   = pix_idx_q;
    assign rx.frame_end = frame_end_q;
    assign rx.err       = err_q;
endmodule
